// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and a wrapping frame counter.
// Optional even-parity trailer bit when PISO_TX_PARITY_EN is defined.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tx_count
);

  localparam int BCW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] tx_count_q, tx_count_d;
`ifdef PISO_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign load_ready = (state_q == IDLE) && reset;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    tx_count_d   = tx_count_q;
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    done_d       = 1'b0;
`ifdef PISO_TX_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_valid && load_ready) begin
          state_d      = SHIFT;
          sout_d       = head_bit(data_in);
          sout_valid_d = 1'b1;
          shreg_d      = advance(data_in);
          bitcnt_d     = BCW'(1);
`ifdef PISO_TX_PARITY_EN
          par_d        = ^data_in;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (bitcnt_q == BCW'(WIDTH)) begin
`ifdef PISO_TX_PARITY_EN
          state_d      = PARITY;
          sout_d       = par_q;
          sout_valid_d = 1'b1;
`else
          state_d    = IDLE;
          done_d     = 1'b1;
          bitcnt_d   = '0;
          tx_count_d = tx_count_q + CNT_W'(1);
`endif
        end else begin
          sout_d       = head_bit(shreg_q);
          sout_valid_d = 1'b1;
          shreg_d      = advance(shreg_q);
          bitcnt_d     = bitcnt_q + BCW'(1);
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        state_d    = IDLE;
        done_d     = 1'b1;
        bitcnt_d   = '0;
        tx_count_d = tx_count_q + CNT_W'(1);
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset aborts any frame in flight without a done pulse or count update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      tx_count_q   <= '0;
`ifdef PISO_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
      tx_count_q   <= tx_count_d;
`ifdef PISO_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);
  assign tx_count   = tx_count_q;

endmodule
